// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the shared n-bit ALU: one request in flight at a time.
// Operands stay registered for the op's latency, and the result comes back over a valid/ready channel.
module alu_op_sequencer #(
  parameter int N       = 4,
  parameter int MUL_LAT = N + 1,
  parameter int DIV_LAT = N + 2,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [2*N-1:0]   alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_div0,
  output logic             busy
);
  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic             r_div0_pend;
  logic             w_accept;
  logic             w_div0;
  logic [CW-1:0]    w_lat;

  assign req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready);
  assign w_accept  = req_valid & req_ready;
  assign w_div0    = (req_op == 3'b011) & (req_b == '0);

  // A divide by zero never waits on the divider.
  always_comb begin
    w_lat = CW'(1);
    if (req_op == 3'b010)                w_lat = CW'(MUL_LAT);
    else if (req_op == 3'b011 && !w_div0) w_lat = CW'(DIV_LAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_div0_pend <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_tag     <= '0;
      rsp_div0    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_EXEC: begin
          if (r_cnt == CW'(1)) begin
            rsp_result <= r_div0_pend ? '0 : alu_result;
            rsp_div0   <= r_div0_pend;
            rsp_tag    <= r_tag;
            rsp_valid  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Accept overrides the RESP drain so back-to-back issue has no bubble.
      if (w_accept) begin
        alu_op      <= req_op;
        alu_a       <= req_a;
        alu_b       <= req_b;
        r_tag       <= req_tag;
        r_cnt       <= w_lat;
        r_div0_pend <= w_div0;
        rsp_valid   <= 1'b0;
        busy        <= 1'b1;
        r_state     <= S_EXEC;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;
  localparam int N = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [N-1:0]     req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_a, alu_b;
  logic [2*N-1:0]   alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*N-1:0]   rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_div0;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  alu_op_sequencer #(.N(N), .MUL_LAT(5), .DIV_LAT(6), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_div0(rsp_div0), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns a nonzero junk value.
  always_comb begin
    logic signed [2*N-1:0] sa, sb;
    sa = {{N{alu_a[N-1]}}, alu_a};
    sb = {{N{alu_b[N-1]}}, alu_b};
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = sa + sb;
      3'b001: alu_result = sa - sb;
      3'b010: alu_result = sa * sb;
      3'b011: alu_result = (alu_b == '0) ? 8'hFF : sa / sb;
      3'b100: alu_result = {4'h0, alu_a & alu_b};
      3'b101: alu_result = {4'h0, alu_a | alu_b};
      3'b110: alu_result = {4'h0, alu_a ^ alu_b};
      default: alu_result = {4'h0, ~alu_a};
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TAG_W-1:0] tag);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tests_run++;
    if ({alu_op, alu_a, alu_b, rsp_result, rsp_tag, rsp_div0, rsp_valid, busy} !== '0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: op=%h a=%h b=%h res=%h tag=%h d0=%b v=%b busy=%b rdy=%b, want all 0 and rdy=1",
               alu_op, alu_a, alu_b, rsp_result, rsp_tag, rsp_div0, rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_add();
    int cyc;
    issue(3'b000, 4'd3, 4'hE, 2'd1);
    wait_rsp(cyc);
    tests_run++;
    if (cyc !== 1) begin tests_failed++; $display("FAIL add_latency: got %0d want 1", cyc); end
    tests_run++;
    if (rsp_result !== 8'h01 || rsp_tag !== 2'd1 || rsp_div0 !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_rsp: res=%h tag=%0d d0=%b busy=%b want 01/1/0/1", rsp_result, rsp_tag, rsp_div0, busy);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL add_drain: v=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_mul();
    int cyc;
    bit unstable;
    issue(3'b010, 4'hD, 4'd5, 2'd2);
    cyc = 99; unstable = 0;
    for (int i = 1; i <= 20; i++) begin
      if (alu_a !== 4'hD || alu_b !== 4'd5 || alu_op !== 3'b010) unstable = 1;
      tick();
      if (rsp_valid) begin cyc = i; break; end
    end
    tests_run++;
    if (cyc !== 5) begin tests_failed++; $display("FAIL mul_latency: got %0d want 5", cyc); end
    tests_run++;
    if (unstable) begin tests_failed++; $display("FAIL mul_operand_hold: got unstable want stable"); end
    tests_run++;
    if (rsp_result !== 8'hF1 || rsp_tag !== 2'd2) begin
      tests_failed++; $display("FAIL mul_rsp: res=%h tag=%0d want F1/2", rsp_result, rsp_tag);
    end
    tick();
  endtask

  task automatic test_div0();
    int cyc;
    issue(3'b011, 4'd7, 4'd0, 2'd0);
    wait_rsp(cyc);
    tests_run++;
    if (cyc !== 1) begin tests_failed++; $display("FAIL div0_latency: got %0d want 1", cyc); end
    tests_run++;
    if (rsp_result !== 8'h00 || rsp_div0 !== 1'b1) begin
      tests_failed++; $display("FAIL div0_rsp: res=%h d0=%b want 00/1", rsp_result, rsp_div0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bad;
    rsp_ready = 1'b0;
    issue(3'b000, 4'd1, 4'd1, 2'd1);
    wait_rsp(cyc);
    tests_run++;
    if (cyc !== 1 || rsp_result !== 8'h02) begin
      tests_failed++; $display("FAIL bp_first: cyc=%0d res=%h want 1/02", cyc, rsp_result);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h02 || rsp_tag !== 2'd1 || req_ready !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL bp_hold: v=%b res=%h tag=%0d rdy=%b want 1/02/1/0", rsp_valid, rsp_result, rsp_tag, req_ready);
    end
    req_op = 3'b100; req_a = 4'hC; req_b = 4'hA; req_tag = 2'd2; req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_op !== 3'b100) begin
      tests_failed++; $display("FAIL bp_accept: v=%b busy=%b op=%b want 0/1/100", rsp_valid, busy, alu_op);
    end
    wait_rsp(cyc);
    tests_run++;
    if (cyc !== 1 || rsp_result !== 8'h08 || rsp_tag !== 2'd2) begin
      tests_failed++; $display("FAIL bp_second: cyc=%0d res=%h tag=%0d want 1/08/2", cyc, rsp_result, rsp_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    issue(3'b011, 4'd6, 4'd3, 2'd1);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid: busy=%b v=%b rdy=%b want 0/0/1", busy, rsp_valid, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rsp_valid) seen = 1; end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL rst_no_rsp: got response want none"); end
  endtask

  task automatic test_div();
    int cyc;
    issue(3'b011, 4'd6, 4'd2, 2'd3);
    wait_rsp(cyc);
    tests_run++;
    if (cyc !== 6) begin tests_failed++; $display("FAIL div_latency: got %0d want 6", cyc); end
    tests_run++;
    if (rsp_result !== 8'h03 || rsp_tag !== 2'd3 || rsp_div0 !== 1'b0) begin
      tests_failed++; $display("FAIL div_rsp: res=%h tag=%0d d0=%b want 03/3/0", rsp_result, rsp_tag, rsp_div0);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_div0();
    test_back_to_back();
    test_reset_mid_op();
    test_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
